// File: rtl/seq_mult_param_if.sv
// Operand/result handshake bundle for seq_mult_param.
// The master drives start and the operands. The slave returns busy, done_flag and the product.
interface seq_mult_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   start;
    logic                   sign_mode;
    logic [WIDTH-1:0]       dataa;
    logic [WIDTH-1:0]       datab;
    logic                   busy;
    logic                   done_flag;
    logic [2*WIDTH-1:0]     product8_8;

    modport master (
        output start, sign_mode, dataa, datab,
        input  busy, done_flag, product8_8
    );

    modport slave (
        input  start, sign_mode, dataa, datab,
        output busy, done_flag, product8_8
    );
endinterface

// File: rtl/seq_mult_param.sv
// Digit-serial WIDTH x WIDTH multiplier that consumes DIGIT multiplier bits per cycle, with a start/busy/done handshake.
// Define SEQ_MULT_SIGNED_EN to honour sign_mode. Without it, the operands are always treated as unsigned.
module seq_mult_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic              clk,
    input  logic              reset_a,
    seq_mult_param_if.slave   bus
);
    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam int unsigned PP_W  = WIDTH + DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    logic               start_d;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic               done_q;
    logic [ACC_W-1:0]   product_q;

    logic               launch_c;
    logic [WIDTH-1:0]   mag_a_c;
    logic [WIDTH-1:0]   mag_b_c;
    logic [DIGIT-1:0]   digit_c;
    logic [PP_W-1:0]    pp_c;
    logic [ACC_W-1:0]   fix_c;

    assign launch_c = bus.start & ~start_d & (state == IDLE);

    // Current multiplier digit and its partial product against the full multiplicand
    assign digit_c = DIGIT'(mag_b >> (DIGIT * cnt));
    assign pp_c    = PP_W'(mag_a) * PP_W'(digit_c);

`ifdef SEQ_MULT_SIGNED_EN
    logic neg;
    logic neg_c;
    logic a_neg_c;
    logic b_neg_c;

    // The most negative value negates to itself, which is its correct unsigned magnitude
    assign a_neg_c = bus.sign_mode & bus.dataa[WIDTH-1];
    assign b_neg_c = bus.sign_mode & bus.datab[WIDTH-1];
    assign mag_a_c = a_neg_c ? WIDTH'(-bus.dataa) : bus.dataa;
    assign mag_b_c = b_neg_c ? WIDTH'(-bus.datab) : bus.datab;
    assign neg_c   = a_neg_c ^ b_neg_c;
    assign fix_c   = neg ? ACC_W'(-acc) : acc;

    always_ff @(posedge clk) begin
        if (reset_a) begin
            neg <= 1'b0;
        end else if (launch_c) begin
            neg <= neg_c;
        end
    end
`else
    logic unused_sign_mode;

    assign unused_sign_mode = bus.sign_mode;
    assign mag_a_c          = bus.dataa;
    assign mag_b_c          = bus.datab;
    assign fix_c            = acc;
`endif

    // Control FSM and datapath; all handshake outputs are registered
    always_ff @(posedge clk) begin
        if (reset_a) begin
            state     <= IDLE;
            start_d   <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
            acc       <= '0;
            cnt       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            start_d <= bus.start;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch_c) begin
                        mag_a  <= mag_a_c;
                        mag_b  <= mag_b_c;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc + (ACC_W'(pp_c) << (DIGIT * cnt));
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(N - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    product_q <= fix_c;
                    done_q    <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done_flag  = done_q;
    assign bus.product8_8 = product_q;
endmodule

// File: tb/tb_seq_mult_param.sv
// Testbench for seq_mult_param. It runs a vector table, random operands checked against an arithmetic
// model, handshake corner sequences, and a second instance with WIDTH = 16 and DIGIT = 4.
module tb_seq_mult_param;
    logic clk = 1'b0;
    logic reset_a;
    always #5 clk = ~clk;

    seq_mult_param_if #(.WIDTH(8))  bus8 ();
    seq_mult_param_if #(.WIDTH(16)) bus16 ();

    seq_mult_param #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus8)
    );

    seq_mult_param #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus16)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: the true mathematical product, reduced to 2*WIDTH bits
    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint pa;
        longint pb;
        pa = longint'(a);
        pb = longint'(b);
`ifdef SEQ_MULT_SIGNED_EN
        if (s && a[7]) pa = pa - 256;
        if (s && b[7]) pb = pb - 256;
`endif
        return 16'(pa * pb);
    endfunction

    // Launch a single 8-bit operation and scramble the inputs right after the launch edge.
    // lat counts the edges after launch until done_flag is seen.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [15:0] prod, output int lat, output int busy_n);
        @(negedge clk);
        bus8.dataa = a; bus8.datab = b; bus8.sign_mode = s; bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.dataa = 8'($urandom); bus8.datab = 8'($urandom); bus8.sign_mode = ~s;
        lat = 0;
        busy_n = 0;
        while (!bus8.done_flag && lat < 50) begin
            if (bus8.busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (bus8.busy) busy_n++;
        prod = bus8.product8_8;
        @(negedge clk);
        check("done_one_cycle", 64'(bus8.done_flag), 64'd0);
        check("busy_falls_with_done", 64'(bus8.busy), 64'd0);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] prod, output int lat);
        @(negedge clk);
        bus16.dataa = a; bus16.datab = b; bus16.sign_mode = 1'b0; bus16.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus16.start = 1'b0;
        bus16.dataa = 16'($urandom); bus16.datab = 16'($urandom);
        lat = 0;
        while (!bus16.done_flag && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        prod = bus16.product8_8;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] prod;
        logic [31:0] prod16;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic        rs;
        logic [15:0] ra16;
        logic [15:0] rb16;
        int          lat;
        int          busy_n;
        int          pulses;

        vecs[0] = '{"u_10x5",    8'd10,  8'd5,   1'b0, 16'd50};
        vecs[1] = '{"u_7x3",     8'd7,   8'd3,   1'b0, 16'd21};
        vecs[2] = '{"u_255x255", 8'd255, 8'd255, 1'b0, 16'hFE01};
        vecs[3] = '{"u_fdx5",    8'hFD,  8'd5,   1'b0, 16'h04F1};
        vecs[4] = '{"zero_a",    8'd0,   8'd77,  1'b0, 16'd0};
`ifdef SEQ_MULT_SIGNED_EN
        vecs[5] = '{"s_fdx5",    8'hFD,  8'd5,   1'b1, 16'hFFF1};
        vecs[6] = '{"s_80x80",   8'h80,  8'h80,  1'b1, 16'h4000};
        vecs[7] = '{"s_80x7f",   8'h80,  8'h7F,  1'b1, 16'hC080};
`else
        vecs[5] = '{"s_fdx5",    8'hFD,  8'd5,   1'b1, 16'h04F1};
        vecs[6] = '{"s_80x80",   8'h80,  8'h80,  1'b1, 16'h4000};
        vecs[7] = '{"s_80x7f",   8'h80,  8'h7F,  1'b1, 16'h3F80};
`endif

        reset_a = 1'b1;
        bus8.start = 1'b0; bus8.sign_mode = 1'b0; bus8.dataa = '0; bus8.datab = '0;
        bus16.start = 1'b0; bus16.sign_mode = 1'b0; bus16.dataa = '0; bus16.datab = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus8.busy), 64'd0);
        check("reset_done", 64'(bus8.done_flag), 64'd0);
        check("reset_product", 64'(bus8.product8_8), 64'd0);
        reset_a = 1'b0;

        foreach (vecs[i]) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].s, prod, lat, busy_n);
            check({vecs[i].name, "_product"}, 64'(prod), 64'(vecs[i].exp));
            check({vecs[i].name, "_latency"}, 64'(lat), 64'd5);
            check({vecs[i].name, "_busy_cycles"}, 64'(busy_n), 64'd6);
        end

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            run8(ra, rb, rs, prod, lat, busy_n);
            check("random_product", 64'(prod), 64'(model8(ra, rb, rs)));
            check("random_latency", 64'(lat), 64'd5);
        end

        // Holding start high for 20 cycles must produce only one operation.
        @(negedge clk);
        bus8.dataa = 8'd7; bus8.datab = 8'd3; bus8.sign_mode = 1'b0; bus8.start = 1'b1;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus8.done_flag) pulses++;
        end
        bus8.start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus8.done_flag) pulses++;
        end
        check("held_start_pulses", 64'(pulses), 64'd1);
        check("held_start_product", 64'(bus8.product8_8), 64'd21);

        // A fresh start edge raised while busy must be dropped, not queued.
        @(negedge clk);
        bus8.dataa = 8'd10; bus8.datab = 8'd5; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        bus8.dataa = 8'd3; bus8.datab = 8'd3; bus8.start = 1'b1;
        pulses = 0;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus8.done_flag) pulses++;
        end
        check("busy_restart_pulses", 64'(pulses), 64'd1);
        check("busy_restart_product", 64'(bus8.product8_8), 64'd50);

        // Reset two edges after launch aborts the operation and clears the result.
        @(negedge clk);
        bus8.dataa = 8'd7; bus8.datab = 8'd3; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        check("midreset_busy", 64'(bus8.busy), 64'd0);
        check("midreset_product", 64'(bus8.product8_8), 64'd0);
        check("midreset_done", 64'(bus8.done_flag), 64'd0);
        reset_a = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus8.done_flag) pulses++;
        end
        check("midreset_no_done", 64'(pulses), 64'd0);
        run8(8'd7, 8'd3, 1'b0, prod, lat, busy_n);
        check("relaunch_product", 64'(prod), 64'd21);
        check("relaunch_latency", 64'(lat), 64'd5);

        // Wide instance: N = 16/4 = 4, so the latency is still 5 edges.
        run16(16'd1000, 16'd3000, prod16, lat);
        check("w16_1000x3000", 64'(prod16), 64'd3000000);
        check("w16_latency", 64'(lat), 64'd5);
        for (int i = 0; i < 10; i++) begin
            ra16 = 16'($urandom); rb16 = 16'($urandom);
            run16(ra16, rb16, prod16, lat);
            check("w16_random_product", 64'(prod16), 64'(longint'(ra16) * longint'(rb16)));
            check("w16_random_latency", 64'(lat), 64'd5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
